mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  read strobe from the control sequencer.
- mem_write  in  1  write strobe from the control sequencer.
- addr  in  32  byte address of the access.
- bus_in  in  32  shared data bus value (write data).
- bus_out  out  32  read data driven onto the shared bus.
- bus_oe  out  1  bus_out valid and driving the shared bus.
- busy  out  1  access in progress; requester holds its strobe.
- fault  out  1  access rejected (one-cycle pulse).
- sram_addr  out  16  byte address to the external 8-bit SRAM.
- sram_wdata  out  8  write byte to the SRAM.
- sram_we  out  1  SRAM write enable.
- sram_oe  out  1  SRAM read enable.
- sram_rdata  in  8  SRAM read byte, valid the cycle after sram_oe with sram_addr.
REQ-002 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-003 States SHALL be IDLE, XFER, RTAIL, RESP.
REQ-004 The block SHALL accept a request only in IDLE; strobe changes in any other state SHALL be ignored.
REQ-005 An access SHALL be rejected when mem_read and mem_write are both high, when addr[1:0] != 0, or when addr[31:16] != 0.
REQ-006 A rejected request SHALL go IDLE->RESP with fault=1 and no SRAM activity. For a rejected read, bus_oe=1 and bus_out=0 for that cycle.
REQ-007 On an accepted request the block SHALL latch addr[15:0], the direction, and bus_in (writes), clear a 2-bit byte counter k, and enter XFER.
REQ-008 In XFER the block SHALL set sram_addr = base + k. For writes, it SHALL drive sram_we=1 and sram_wdata = latched word byte k (little-endian, bits 8k+7:8k). For reads, it SHALL drive sram_oe=1.
REQ-009 XFER SHALL last exactly 4 cycles (k = 0..3). At k=3 it SHALL go to RESP for writes and to RTAIL for reads.
REQ-010 Read byte k SHALL be captured from sram_rdata in the cycle after the cycle that issued k; byte 3 is captured in RTAIL. RTAIL SHALL last 1 cycle, then go to RESP.
REQ-011 RESP SHALL last 1 cycle and then return to IDLE. For a read it SHALL drive bus_oe=1 and bus_out = the assembled word. For a write it SHALL drive bus_oe=0.
REQ-012 busy SHALL be 1 exactly in XFER and RTAIL, and 0 in IDLE and RESP.
REQ-013 Latency from the request-sample edge to RESP SHALL be 5 cycles for a write, 6 cycles for a read, and 1 cycle for a fault.
REQ-014 sram_we and sram_oe SHALL never be high in the same cycle, and both SHALL be 0 outside XFER.
REQ-015 bus_oe SHALL be 0 in every state except RESP.
REQ-016 A request still held high in RESP SHALL NOT start a new access. The next access SHALL start only if the strobe is sampled high in IDLE.
REQ-017 base + k SHALL be computed in 16 bits. Alignment guarantees no carry out of bits [1:0].

Reset
REQ-018 While reset is high, state SHALL become IDLE, and busy, fault, bus_oe, sram_we, sram_oe, sram_addr, sram_wdata and bus_out SHALL all be 0.
REQ-019 Reset asserted mid-access SHALL abort the access in the next cycle with no further SRAM strobes; bytes already written SHALL remain written.
REQ-020 Reset SHALL take priority over any simultaneous request.

Structure
REQ-021 The state enum, SRAM_AW=16 and BYTES_PER_WORD=4 SHALL live in a shared package, mem_pkg.
REQ-022 The block SHALL be a single module with no sub-modules. Byte assembly SHALL use a 32-bit shift-in register internal to the module.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Write addr=0x0000_0100, bus_in=0xDEADBEEF -> SRAM bytes 0x100..0x103 = EF,BE,AD,DE; busy high for 4 cycles; RESP at cycle 5; fault=0.
- Read addr=0x0000_0100 after the previous write -> bus_oe=1, bus_out=0xDEADBEEF at cycle 6; busy high for 5 cycles.
- Read addr=0x0000_0102 (misaligned) -> fault=1, bus_oe=1, bus_out=0 at cycle 1; no sram_oe.
- mem_read=mem_write=1, addr=0x10 -> fault at cycle 1; no SRAM strobes.
- Write addr=0x0001_0000 (out of range) -> fault at cycle 1; no sram_we.
- Reset at XFER k=1 of a write to 0x200 -> only 0x200 and 0x201 written; next cycle IDLE with all outputs 0; a following read accepted normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding, SRAM geometry and request validation for mem_responder
package mem_pkg;
    localparam int SRAM_AW = 16;
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [1:0] {IDLE, XFER, RTAIL, RESP} state_t;
    function automatic logic req_reject(input logic rd, input logic wr, input logic [31:0] a);
        return (rd && wr) || (a[1:0] != 2'b00) || (a[31:16] != 16'h0000);
    endfunction
endpackage

// File: rtl/mem_responder.sv
// mem_responder: serves 32-bit bus reads/writes as four byte accesses to an 8-bit synchronous SRAM
module mem_responder
    import mem_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        addr,
    input  logic [31:0]        bus_in,
    output logic [31:0]        bus_out,
    output logic               bus_oe,
    output logic               busy,
    output logic               fault,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [7:0]         sram_wdata,
    output logic               sram_we,
    output logic               sram_oe,
    input  logic [7:0]         sram_rdata
);
    state_t             r_state;
    state_t             w_next;
    logic [SRAM_AW-1:0] r_base;
    logic [31:0]        r_wdata;
    logic [31:0]        r_shift;
    logic [1:0]         r_k;
    logic               r_rd;
    logic               r_fault;
    logic               w_req;
    logic               w_capture;
    logic               w_last;
    logic [31:0]        w_wbyte;

    assign w_req     = mem_read | mem_write;
    assign w_last    = r_k == 2'(BYTES_PER_WORD - 1);
    assign w_capture = (r_state == XFER && r_k != 2'd0) || r_state == RTAIL;
    assign w_wbyte   = r_wdata >> {r_k, 3'b000};

    // state register
    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_next;
    end

    // next state and state-decoded outputs
    always_comb begin
        w_next     = r_state;
        busy       = 1'b0;
        fault      = 1'b0;
        bus_oe     = 1'b0;
        bus_out    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_we    = 1'b0;
        sram_oe    = 1'b0;
        case (r_state)
            IDLE: w_next = !w_req ? IDLE : req_reject(mem_read, mem_write, addr) ? RESP : XFER;
            XFER: begin
                busy       = 1'b1;
                sram_addr  = r_base + SRAM_AW'(r_k);
                sram_we    = !r_rd;
                sram_oe    = r_rd;
                sram_wdata = r_rd ? 8'h00 : w_wbyte[7:0];
                w_next     = !w_last ? XFER : r_rd ? RTAIL : RESP;
            end
            RTAIL: begin
                busy   = 1'b1;
                w_next = RESP;
            end
            RESP: begin
                fault   = r_fault;
                bus_oe  = r_rd;
                bus_out = (r_rd && !r_fault) ? r_shift : '0;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // request latch, byte counter and little-endian shift-in of read bytes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base  <= '0;
            r_wdata <= '0;
            r_shift <= '0;
            r_k     <= '0;
            r_rd    <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            if (r_state == IDLE && w_req) begin
                r_base  <= addr[SRAM_AW-1:0];
                r_wdata <= bus_in;
                r_rd    <= mem_read & ~mem_write;
                r_fault <= req_reject(mem_read, mem_write, addr);
                r_k     <= '0;
                r_shift <= '0;
            end else if (r_state == XFER) begin
                r_k <= r_k + 2'd1;
            end
            if (w_capture) r_shift <= {sram_rdata, r_shift[31:8]};
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench with a per-cycle transaction model and an 8-bit SRAM stand-in
module tb_mem_responder;
    typedef struct packed {
        logic        busy;
        logic        fault;
        logic        bus_oe;
        logic        sram_we;
        logic        sram_oe;
        logic [31:0] bus_out;
        logic [15:0] sram_addr;
        logic [7:0]  sram_wdata;
    } outs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] bus_in = '0;
    logic [31:0] bus_out;
    logic        bus_oe;
    logic        busy;
    logic        fault;
    logic [15:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic        sram_we;
    logic        sram_oe;
    logic [7:0]  sram_rdata = 8'h00;

    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    logic [7:0]  sram [0:65535];
    logic [7:0]  mdl [0:65535];

    outs_t       exp_q[$];
    logic        chk_on = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt = 0;
    int          fault_cnt = 0;
    int          strobe_cnt = 0;
    int          oe_cnt = 0;
    logic [31:0] last_bus = '0;

    mem_responder dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .busy(busy), .fault(fault), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_we(sram_we), .sram_oe(sram_oe), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // synchronous byte-wide SRAM: read data appears the cycle after sram_oe
    always @(posedge clk) begin
        if (pre_we) sram[pre_addr] <= pre_data;
        if (sram_we) sram[sram_addr] <= sram_wdata;
        if (sram_oe) sram_rdata <= sram[sram_addr];
    end

    // compare every cycle's outputs against the model; idle outputs when nothing is queued
    always @(negedge clk) begin
        if (chk_on) begin
            outs_t e;
            outs_t a;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            a = '{busy, fault, bus_oe, sram_we, sram_oe, bus_out, sram_addr, sram_wdata};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t actual busy=%b fault=%b oe=%b we=%b soe=%b bus=%h sa=%h wd=%h required busy=%b fault=%b oe=%b we=%b soe=%b bus=%h sa=%h wd=%h",
                         $time, a.busy, a.fault, a.bus_oe, a.sram_we, a.sram_oe, a.bus_out, a.sram_addr, a.sram_wdata,
                         e.busy, e.fault, e.bus_oe, e.sram_we, e.sram_oe, e.bus_out, e.sram_addr, e.sram_wdata);
            end
            if (busy) busy_cnt++;
            if (fault) fault_cnt++;
            if (sram_we || sram_oe) strobe_cnt++;
            if (bus_oe) begin
                oe_cnt++;
                last_bus = bus_out;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic clr_stats();
        busy_cnt = 0;
        fault_cnt = 0;
        strobe_cnt = 0;
        oe_cnt = 0;
        last_bus = '0;
    endtask

    // issue one request, queue the cycles it must produce, hold strobes through RESP
    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        outs_t o;
        int n;
        logic rej;
        logic is_rd;
        logic [15:0] b;
        clr_stats();
        rej = (rd && wr) || a[1:0] != 2'b00 || a[31:16] != 16'h0000;
        is_rd = rd && !wr;
        b = a[15:0];
        exp_q.push_back('0);
        if (rej) begin
            o = '0;
            o.fault = 1'b1;
            o.bus_oe = is_rd;
            exp_q.push_back(o);
            n = 1;
        end else if (wr) begin
            for (int k = 0; k < 4; k++) begin
                o = '0;
                o.busy = 1'b1;
                o.sram_we = 1'b1;
                o.sram_addr = b + 16'(k);
                o.sram_wdata = d[8*k +: 8];
                exp_q.push_back(o);
                mdl[b + 16'(k)] = d[8*k +: 8];
            end
            exp_q.push_back('0);
            n = 5;
        end else begin
            for (int k = 0; k < 4; k++) begin
                o = '0;
                o.busy = 1'b1;
                o.sram_oe = 1'b1;
                o.sram_addr = b + 16'(k);
                exp_q.push_back(o);
            end
            o = '0;
            o.busy = 1'b1;
            exp_q.push_back(o);
            o = '0;
            o.bus_oe = 1'b1;
            o.bus_out = {mdl[b + 16'd3], mdl[b + 16'd2], mdl[b + 16'd1], mdl[b]};
            exp_q.push_back(o);
            n = 6;
        end
        mem_read = rd;
        mem_write = wr;
        addr = a;
        bus_in = d;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        outs_t o;
        mem_read = 1'b1;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pre_we = 1'b1;
            pre_addr = 16'h0200 + 16'(i);
            pre_data = 8'hAA;
            mdl[16'h0200 + 16'(i)] = 8'hAA;
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
        reset = 1'b0;
        mem_read = 1'b0;

        req(1'b0, 1'b1, 32'h0000_0100, 32'hDEADBEEF);
        chk("wr_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("wr_fault", 32'(fault_cnt), 32'd0);
        chk("wr_sram_word", {sram[16'h0103], sram[16'h0102], sram[16'h0101], sram[16'h0100]}, 32'hDEADBEEF);
        chk("wr_sram_byte0", 32'(sram[16'h0100]), 32'h0000_00EF);

        req(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        chk("rd_busy_cycles", 32'(busy_cnt), 32'd5);
        chk("rd_data", last_bus, 32'hDEADBEEF);
        chk("rd_oe_cycles", 32'(oe_cnt), 32'd1);

        req(1'b1, 1'b0, 32'h0000_0102, 32'h0);
        chk("misaligned_fault", 32'(fault_cnt), 32'd1);
        chk("misaligned_strobes", 32'(strobe_cnt), 32'd0);
        chk("misaligned_oe", 32'(oe_cnt), 32'd1);
        chk("misaligned_bus", last_bus, 32'h0);

        req(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678);
        chk("both_fault", 32'(fault_cnt), 32'd1);
        chk("both_strobes", 32'(strobe_cnt), 32'd0);

        req(1'b0, 1'b1, 32'h0001_0000, 32'hCAFE_F00D);
        chk("range_fault", 32'(fault_cnt), 32'd1);
        chk("range_strobes", 32'(strobe_cnt), 32'd0);
        chk("range_busy", 32'(busy_cnt), 32'd0);

        clr_stats();
        exp_q.push_back('0);
        for (int k = 0; k < 2; k++) begin
            o = '0;
            o.busy = 1'b1;
            o.sram_we = 1'b1;
            o.sram_addr = 16'h0200 + 16'(k);
            o.sram_wdata = (k == 0) ? 8'h44 : 8'h33;
            exp_q.push_back(o);
        end
        mdl[16'h0200] = 8'h44;
        mdl[16'h0201] = 8'h33;
        mem_write = 1'b1;
        addr = 32'h0000_0200;
        bus_in = 32'h1122_3344;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_write = 1'b0;
        chk("abort_we_cycles", 32'(strobe_cnt), 32'd2);
        @(posedge clk);
        #1;
        chk("abort_sram_word", {sram[16'h0203], sram[16'h0202], sram[16'h0201], sram[16'h0200]}, 32'hAAAA_3344);

        req(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        chk("post_abort_rd", last_bus, 32'hAAAA_3344);
        chk("post_abort_busy", 32'(busy_cnt), 32'd5);

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
